// File: rtl/onehot_decode_fifo.sv
// Small FIFO of 3-bit codes whose head is presented as a one-hot byte.
// Storage is a register array read combinationally so y follows the head one cycle after accept.
module onehot_decode_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic [2:0]               in_code,
   output logic                     in_ready,
   output logic [7:0]               y,
   output logic                     y_valid,
   input  logic                     y_ready,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [2:0]    mem [DEPTH];
   logic [PW-1:0] wr_ptr_reg;
   logic [PW-1:0] rd_ptr_reg;
   logic [CW-1:0] count_reg;
   logic [CW-1:0] count_next;
   logic          overflow_reg;
   logic          accept;
   logic          pop;
   logic [2:0]    head;

   // in_ready depends only on the count register, never on y_ready.
   assign in_ready = (count_reg < CW'(DEPTH));
   assign y_valid  = (count_reg != '0);
   assign accept   = in_valid && in_ready;
   assign pop      = y_valid && y_ready;
   assign head     = mem[rd_ptr_reg];
   assign count    = count_reg;
   assign overflow = overflow_reg;

   always_comb begin
      count_next = count_reg;
      case ({accept, pop})
         2'b10:   count_next = count_reg + CW'(1);
         2'b01:   count_next = count_reg - CW'(1);
         default: count_next = count_reg;
      endcase
   end

   // Payload storage carries no reset; pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (accept) begin
         mem[wr_ptr_reg] <= in_code;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         overflow_reg <= 1'b0;
      end else begin
         if (accept) begin
            wr_ptr_reg <= wr_ptr_reg + PW'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + PW'(1);
         end
         count_reg <= count_next;
         if (in_valid && !in_ready) begin
            overflow_reg <= 1'b1;
         end
      end
   end

   // One-hot decode of the head, forced to zero while the queue is empty.
   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_decode
         assign y[gi] = y_valid && (head == 3'(gi));
      end
   endgenerate

endmodule

// File: tb/tb_onehot_decode_fifo.sv
// Scoreboard bench for onehot_decode_fifo: expected one-hot bytes are queued on accept
// and compared against y every cycle, consumed on pop.
module tb_onehot_decode_fifo;

   localparam int DEPTH = 4;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic [2:0] in_code;
   logic       in_ready;
   logic [7:0] y;
   logic       y_valid;
   logic       y_ready;
   logic [2:0] count;
   logic       overflow;

   int         n_checks;
   int         n_errors;
   logic [7:0] exp_q[$];
   logic       m_ovf;

   onehot_decode_fifo #(.DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_code  (in_code),
      .in_ready (in_ready),
      .y        (y),
      .y_valid  (y_valid),
      .y_ready  (y_ready),
      .count    (count),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Entered just after a falling edge: drive, sample mid-low-phase, update model, advance.
   task automatic cycle(input logic v, input logic [2:0] c, input logic r);
      logic       acc;
      logic       pp;
      logic [7:0] one;
      logic [7:0] got;
      int         m_count;
      one      = 8'h01;
      in_valid = v;
      in_code  = c;
      y_ready  = r;
      #1;
      m_count = exp_q.size();
      check("count", 32'(count), 32'(m_count));
      check("in_ready", 32'(in_ready), 32'(m_count < DEPTH));
      check("y_valid", 32'(y_valid), 32'(m_count > 0));
      check("overflow", 32'(overflow), 32'(m_ovf));
      if (m_count > 0) check("y_head", 32'(y), 32'(exp_q[0]));
      else             check("y_empty", 32'(y), 32'h0);
      acc = v && (m_count < DEPTH);
      pp  = (m_count > 0) && r;
      if (pp) begin
         got = exp_q.pop_front();
         $display("pop    y=%02h count_before=%0d", got, m_count);
      end
      if (acc) begin
         exp_q.push_back(one << c);
         $display("accept code=%0d count_before=%0d", c, m_count);
      end else if (v) begin
         m_ovf = 1'b1;
         $display("drop   code=%0d (full)", c);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drain();
      for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, 3'd0, 1'b1);
   endtask

   initial begin
      int accepted;
      int iter;
      clk      = 1'b0;
      rst      = 1'b1;
      in_valid = 1'b0;
      in_code  = 3'd0;
      y_ready  = 1'b0;
      n_checks = 0;
      n_errors = 0;
      m_ovf    = 1'b0;
      #1;
      check("rst_count", 32'(count), 32'h0);
      check("rst_y", 32'(y), 32'h0);
      check("rst_y_valid", 32'(y_valid), 32'h0);
      check("rst_in_ready", 32'(in_ready), 32'h1);
      check("rst_overflow", 32'(overflow), 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // Single code held until consumed
      cycle(1'b1, 3'd5, 1'b0);
      check("single_y", 32'(y), 32'h20);
      for (int i = 0; i < 3; i++) cycle(1'b0, 3'd0, 1'b0);
      cycle(1'b0, 3'd0, 1'b1);
      cycle(1'b0, 3'd0, 1'b0);

      // Full sweep of all codes with the consumer always ready
      for (int c = 0; c < 8; c++) cycle(1'b1, 3'(c), 1'b1);
      drain();

      // Fill, then offer one more while full
      for (int c = 1; c <= 4; c++) cycle(1'b1, 3'(c), 1'b0);
      cycle(1'b1, 3'd6, 1'b0);
      check("full_count", 32'(count), 32'd4);
      check("full_overflow", 32'(overflow), 32'h1);
      drain();

      // Full with a simultaneous pop: no accept that cycle, accept on the next
      for (int c = 0; c < 4; c++) cycle(1'b1, 3'(c + 2), 1'b0);
      cycle(1'b1, 3'd7, 1'b1);
      check("fullpop_count", 32'(count), 32'd3);
      cycle(1'b1, 3'd7, 1'b0);
      check("after_fullpop_count", 32'(count), 32'd4);
      drain();

      // Wrap-around with random consumer readiness
      accepted = 0;
      iter     = 0;
      while ((accepted < 10 || exp_q.size() > 0) && iter < 200) begin
         if (accepted < 10) begin
            if (exp_q.size() < DEPTH) accepted++;
            cycle(1'b1, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
         end else begin
            cycle(1'b0, 3'd0, 1'($urandom_range(0, 1)));
         end
         check("count_le_depth", 32'(count <= 3'(DEPTH)), 32'h1);
         iter++;
      end
      check("wrap_done", 32'(iter < 200), 32'h1);

      // Asynchronous reset between edges with two codes queued
      cycle(1'b1, 3'd1, 1'b0);
      cycle(1'b0, 3'd0, 1'b0);
      in_valid = 1'b1;
      in_code  = 3'd4;
      cycle(1'b1, 3'd4, 1'b0);
      in_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check("arst_y_valid", 32'(y_valid), 32'h0);
      check("arst_y", 32'(y), 32'h0);
      check("arst_count", 32'(count), 32'h0);
      check("arst_overflow", 32'(overflow), 32'h0);
      check("arst_in_ready", 32'(in_ready), 32'h1);
      exp_q.delete();
      m_ovf = 1'b0;
      #1;
      rst = 1'b0;
      @(negedge clk);

      // First edge after reset accepts normally
      cycle(1'b1, 3'd3, 1'b0);
      check("post_rst_y", 32'(y), 32'h08);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/onehot_decode_fifo.md
ONEHOT_DECODE_FIFO -- requirements
Module: onehot_decode_fifo

Interface
REQ-001 Parameter DEPTH, default 4, meaning: queue depth in codes; power of two, at least 2.
REQ-002 The block SHALL have one clock, clk, and an asynchronous, active-high reset, rst.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 in_valid  input  1  producer presents in_code this cycle.
REQ-006 in_code  input  3  binary code 0..7 to decode.
REQ-007 in_ready  output  1  block can accept a code this cycle.
REQ-008 y  output  8  one-hot decode of the head code; bit n set for code n.
REQ-009 y_valid  output  1  y holds a queued code.
REQ-010 y_ready  input  1  consumer takes y this cycle.
REQ-011 count  output  clog2(DEPTH)+1  number of queued codes, 0..DEPTH.
REQ-012 overflow  output  1  sticky flag for a code offered while full.

Function
REQ-013 Accept SHALL occur when in_valid=1 and in_ready=1 at a clk edge: in_code is written at the write pointer, and the write pointer increments.
REQ-014 Pop SHALL occur when y_valid=1 and y_ready=1 at a clk edge: the read pointer increments.
REQ-015 in_ready SHALL equal (count < DEPTH), decoded from registers only, with no combinational path from y_ready.
REQ-016 y_valid SHALL equal (count > 0).
REQ-017 y SHALL equal 8'b1 shifted left by the head code when y_valid=1, and 8'h00 when y_valid=0; exactly one bit is set whenever y_valid=1.
REQ-018 Latency SHALL be one cycle: a code accepted at edge k appears on y/y_valid after edge k when the queue was empty before edge k.
REQ-019 Codes SHALL leave in acceptance order (FIFO); y and the head code SHALL be held stable while y_valid=1 and y_ready=0.
REQ-020 count update: +1 on accept only, -1 on pop only, unchanged on simultaneous accept and pop.
REQ-021 Full (count=DEPTH): in_ready=0, so no accept occurs even if a pop happens in the same cycle; in_ready returns to 1 in the cycle after the pop.
REQ-022 Empty (count=0): no pop occurs regardless of y_ready; a simultaneous in_valid is accepted normally.
REQ-023 Read and write pointers SHALL be clog2(DEPTH) bits wide and wrap modulo DEPTH with no gap or duplicate entry.
REQ-024 overflow SHALL set at the clk edge where in_valid=1 and in_ready=0, and stay at 1 until reset; the offered code is dropped.
REQ-025 Codes are 3-bit, so no invalid input exists; every value 0..7 SHALL map to its one-hot output.

Reset
REQ-026 rst=1 SHALL immediately, without waiting for clk, force: pointers=0, count=0, y_valid=0, y=8'h00, overflow=0, in_ready=1.
REQ-027 Assertion of rst mid-operation SHALL discard all queued codes; no accept or pop occurs while rst=1.
REQ-028 After rst deasserts, the first clk edge SHALL accept normally.

Verification
REQ-029 Single code: write 3'd5 into an empty queue with y_ready=0 -> the next cycle gives y=8'b0010_0000, y_valid=1, count=1; y is held until y_ready=1, then y_valid=0 and y=8'h00.
REQ-030 Full sweep: push codes 0..7 back-to-back with y_ready=1 -> y shows 8'h01, 8'h02, ... 8'h80 in order, one per cycle, one cycle after each accept.
REQ-031 Fill and overflow: push 1,2,3,4 with y_ready=0, then push 6 -> count=4 and in_ready=0; 6 is dropped and overflow=1; draining gives 8'h02, 8'h04, 8'h08, 8'h10.
REQ-032 Full with simultaneous pop: at count=4, in_valid=1 and y_ready=1 -> one pop and no accept, count=3, overflow=1; the next cycle accepts.
REQ-033 Wrap-around: perform 10 accepts and pops interleaved with random y_ready -> output order matches input order across pointer wrap, and count never exceeds 4.
REQ-034 Async reset: assert rst between clk edges with count=2 -> y_valid=0, y=8'h00, count=0 and overflow=0 before the next edge.
